peripheral_arbiter: RTL



---
 rtl/peripheral_arbiter_if.sv | 63 ++++++
 rtl/peripheral_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/peripheral_arbiter_if.sv
// peripheral_arbiter_if
// Bundles the two requester ports and the bridge handshake of the
// peripheral arbiter into one interface.
//   slave  : arbiter view (takes requests, drives responses and the bridge)
//   master : environment view (requesters and bridge)
// Ports per requester n (0 = memory stage, 1 = debug/DMA):
//   reqn_start/address/write/data_in/wstrb  request and its fields
//   reqn_data_out/done/error                response
// Bridge: peri_start/address/write/data_in/wstrb/cache_ready out of the
//   arbiter, peri_data_out/done into it. grant is a debug view of the
//   current or most recent grant.
interface peripheral_arbiter_if;
  logic        req0_start;
  logic [31:0] req0_address;
  logic        req0_write;
  logic [31:0] req0_data_in;
  logic [3:0]  req0_wstrb;
  logic [31:0] req0_data_out;
  logic        req0_done;
  logic        req0_error;

  logic        req1_start;
  logic [31:0] req1_address;
  logic        req1_write;
  logic [31:0] req1_data_in;
  logic [3:0]  req1_wstrb;
  logic [31:0] req1_data_out;
  logic        req1_done;
  logic        req1_error;

  logic        peri_start;
  logic [31:0] peri_address;
  logic        peri_write;
  logic [31:0] peri_data_in;
  logic [3:0]  peri_wstrb;
  logic [31:0] peri_data_out;
  logic        peri_done;
  logic        peri_cache_ready;

  logic        grant;

  modport slave (
    input  req0_start, req0_address, req0_write, req0_data_in, req0_wstrb,
    output req0_data_out, req0_done, req0_error,
    input  req1_start, req1_address, req1_write, req1_data_in, req1_wstrb,
    output req1_data_out, req1_done, req1_error,
    output peri_start, peri_address, peri_write, peri_data_in, peri_wstrb,
    input  peri_data_out, peri_done,
    output peri_cache_ready,
    output grant
  );

  modport master (
    output req0_start, req0_address, req0_write, req0_data_in, req0_wstrb,
    input  req0_data_out, req0_done, req0_error,
    output req1_start, req1_address, req1_write, req1_data_in, req1_wstrb,
    input  req1_data_out, req1_done, req1_error,
    input  peri_start, peri_address, peri_write, peri_data_in, peri_wstrb,
    output peri_data_out, peri_done,
    input  peri_cache_ready,
    input  grant
  );
endinterface

// File: rtl/peripheral_arbiter.sv
// peripheral_arbiter
// Round-robin arbiter and sequencer in front of the single-outstanding
// peripheral bridge. Grants one of two requesters, rejects addresses
// outside the peripheral window, runs the START/DONE/CACHE_READY
// handshake and bounds each bridge access with a timeout.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : peripheral_arbiter_if.slave (requesters, bridge, grant)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a request; grants and checks the window
// ERRRESP | window miss; error response to the granted port
// BUSY    | bridge access in flight; timeout counter running
// DRAIN   | timed out, error already returned; waiting for bridge DONE
// RELEASE | CACHE_READY high until bridge DONE drops; then respond
module peripheral_arbiter #(
  parameter logic [31:0] PERI_BASE      = 32'h8000_0000,
  parameter logic [31:0] PERI_SIZE      = 32'h1000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input logic           clk,
  input logic           rst,
  peripheral_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ERRRESP, BUSY, DRAIN, RELEASE} state_t;

  localparam logic        TO_ENABLE = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYCLES - 1);

  state_t state_q, state_d;
  logic        grant_q, grant_d;
  logic [31:0] cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic        start_q, start_d;
  logic        cr_q, cr_d;
  logic [31:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]        done_q, done_d;
  logic [1:0]        err_q, err_d;
  logic [1:0][31:0]  dout_q, dout_d;

  logic        any_req, sel;
  logic [31:0] sel_addr, sel_wdata;
  logic        sel_write;
  logic [3:0]  sel_wstrb;
  logic        in_win;

  // Tie goes to the port that did not win last time.
  assign any_req   = bus.req0_start | bus.req1_start;
  assign sel       = (bus.req0_start && bus.req1_start) ? ~grant_q : bus.req1_start;
  assign sel_addr  = sel ? bus.req1_address : bus.req0_address;
  assign sel_write = sel ? bus.req1_write   : bus.req0_write;
  assign sel_wdata = sel ? bus.req1_data_in : bus.req0_data_in;
  assign sel_wstrb = sel ? bus.req1_wstrb   : bus.req0_wstrb;
  // Unsigned wrap makes addresses below the base fail the compare too.
  assign in_win    = (sel_addr - PERI_BASE) < PERI_SIZE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b1;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      start_q <= 1'b0;
      cr_q    <= 1'b0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      start_q <= start_d;
      cr_q    <= cr_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      done_q  <= done_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    start_d = start_q;
    cr_d    = cr_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    done_d  = '0;
    err_d   = '0;
    dout_d  = dout_q;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = sel;
          addr_d  = sel_addr;
          write_d = sel_write;
          wdata_d = sel_wdata;
          wstrb_d = sel_wstrb;
          if (in_win) begin
            state_d = BUSY;
            start_d = 1'b1;
            cnt_d   = '0;
            pend_d  = 1'b1;
          end else begin
            state_d = ERRRESP;
          end
        end
      end
      ERRRESP: begin
        done_d[grant_q] = 1'b1;
        err_d[grant_q]  = 1'b1;
        dout_d[grant_q] = ERR_DATA;
        state_d         = IDLE;
      end
      BUSY: begin
        cnt_d = cnt_q + 32'd1;
        if (bus.peri_done) begin
          if (!write_q) dout_d[grant_q] = bus.peri_data_out;
          start_d = 1'b0;
          cr_d    = 1'b1;
          state_d = RELEASE;
        end else if (TO_ENABLE && cnt_q == TO_LAST) begin
          // Answer the requester now; the bridge still owns the access.
          done_d[grant_q] = 1'b1;
          err_d[grant_q]  = 1'b1;
          dout_d[grant_q] = ERR_DATA;
          pend_d          = 1'b0;
          state_d         = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.peri_done) begin
          start_d = 1'b0;
          cr_d    = 1'b1;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!bus.peri_done) begin
          cr_d = 1'b0;
          if (pend_q) begin
            done_d[grant_q] = 1'b1;
            pend_d          = 1'b0;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req0_done        = done_q[0];
  assign bus.req1_done        = done_q[1];
  assign bus.req0_error       = err_q[0];
  assign bus.req1_error       = err_q[1];
  assign bus.req0_data_out    = dout_q[0];
  assign bus.req1_data_out    = dout_q[1];
  assign bus.peri_start       = start_q;
  assign bus.peri_address     = addr_q;
  assign bus.peri_write       = write_q;
  assign bus.peri_data_in     = wdata_q;
  assign bus.peri_wstrb       = wstrb_q;
  assign bus.peri_cache_ready = cr_q;
  assign bus.grant            = grant_q;

endmodule
